// File: rtl/alu_req_arbiter.sv
// Two-channel round-robin sequencer sharing one combinational ALU; one op in flight.
// Optional divide-by-zero short-circuit enabled by defining DIV_ZERO_CHK_EN.
module alu_req_arbiter #(
    parameter int W       = 8,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [3:0]   req_op0,
    input  logic [3:0]   req_op1,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_b1,
    output logic [1:0]   resp_valid,
    input  logic [1:0]   resp_ready,
    output logic [W-1:0] resp_res,
    output logic         resp_err,
    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_res,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   alu_op_q, alu_op_d;
    logic [W-1:0] alu_a_q, alu_a_d;
    logic [W-1:0] alu_b_q, alu_b_d;
    logic [W-1:0] resp_res_q, resp_res_d;
    logic         resp_err_q, resp_err_d;

    logic         grant;
    logic         accept;
    logic         div_zero;
    logic [3:0]   sel_op;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;

    // On contention the channel that did not win last time is granted.
    always_comb begin
        grant = req_valid[1];
        if (req_valid == 2'b11) begin
            grant = ~last_grant_q;
        end
        req_ready = 2'b00;
        if (state_q == IDLE && (|req_valid) && !rst) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
        accept = |(req_valid & req_ready);
        sel_op = grant ? req_op1 : req_op0;
        sel_a  = grant ? req_a1  : req_a0;
        sel_b  = grant ? req_b1  : req_b0;
`ifdef DIV_ZERO_CHK_EN
        div_zero = (sel_op == 4'b0011 || sel_op == 4'b0100) && (sel_b == '0);
`else
        div_zero = 1'b0;
`endif
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        resp_res_d   = resp_res_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_op_d     = sel_op;
                    alu_a_d      = sel_a;
                    alu_b_d      = sel_b;
                    last_grant_d = grant;
                    cnt_d        = CNT_INIT;
                    if (div_zero) begin
                        resp_res_d = {W{1'b1}};
                        resp_err_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d    = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    resp_res_d = alu_res;
                    resp_err_d = 1'b0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // last_grant_q names the owner of the op in flight.
                if (resp_ready[last_grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            alu_op_q     <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            resp_res_q   <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            resp_res_q   <= resp_res_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = (state_q == DONE) ? (last_grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_res   = resp_res_q;
    assign resp_err   = resp_err_q;
    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign busy       = (state_q != IDLE);

endmodule
